fifo_arbiter: RTL and testbench
===============================

FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter width, default 8, data word width in bits, shared by all inputs and the output.
REQ-002 Parameter timeout, default 16, number of idle cycles in LOCKED before the grant is revoked; legal range 2..65535.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in0_data..in3_data  input  width  per-port write data.
REQ-006 in0_last..in3_last  input  1  per-port end-of-packet flag, qualified by the port's stb.
REQ-007 in0_stb..in3_stb  input  1  per-port word valid.
REQ-008 in0_ack..in3_ack  output  1  per-port word accepted.
REQ-009 out_data  output  width  registered output word, written into the downstream fifo data_in.
REQ-010 out_last  output  1  registered end-of-packet flag travelling with out_data.
REQ-011 out_stb  output  1  registered output word valid, connected to the fifo data_in_stb.
REQ-012 out_ack  input  1  downstream accept, connected to the fifo data_in_ack.
REQ-013 grant  output  2  index of the currently or most recently granted port.
REQ-014 locked  output  1  high while in LOCKED.
REQ-015 timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-016 The FSM SHALL have two states: IDLE and LOCKED.
REQ-017 In IDLE, when any inN_stb is high, the block SHALL select the first requesting port in round-robin order starting at (last_grant+1) mod 4, then load grant, enter LOCKED at the next edge, and clear the idle counter.
REQ-018 In IDLE all inN_ack SHALL be low, and no input word SHALL be accepted during the arbitration cycle.
REQ-019 In LOCKED, in_ack of the granted port SHALL be high, combinationally, exactly when out_stb is low or out_ack is high; all other acks SHALL be low.
REQ-020 A transfer occurs when stb and ack of the granted port are both high; out_data and out_last SHALL be loaded from that port, and out_stb SHALL be set, at the same edge.
REQ-021 out_stb SHALL clear at an edge where out_stb and out_ack are both high and no new transfer occurs; a simultaneous consume and transfer SHALL keep out_stb high and replace the word, giving one word per cycle sustained.
REQ-022 out_data and out_last SHALL remain stable while out_stb is high and out_ack is low.
REQ-023 A transfer with last high SHALL return the FSM to IDLE and set last_grant to grant at that edge; packets from different ports SHALL never interleave at the output.
REQ-024 In LOCKED, a 16-bit idle counter SHALL increment on each cycle with no transfer and clear on each transfer.
REQ-025 When the idle counter reaches timeout-1 with no transfer, the FSM SHALL return to IDLE, set last_grant to grant, and pulse timeout_err for one cycle.
REQ-026 If a transfer and the timeout condition occur in the same cycle, the transfer SHALL win: the counter clears and no timeout occurs.
REQ-027 grant SHALL hold its value in IDLE, and locked SHALL equal (state == LOCKED).
REQ-028 Input-to-output latency SHALL be one edge: the word accepted at edge k is presented with out_stb high after edge k.

Reset
REQ-029 While rst is high at an edge, the block SHALL enter IDLE and clear out_stb, out_last, out_data, grant, timeout_err and the idle counter, and set last_grant to 3, so that port 0 has first priority.
REQ-030 A reset asserted mid-packet SHALL discard any buffered output word and the grant, and no ack SHALL be asserted in the cycle after reset.

Verification
REQ-031 Single packet: after reset, in2 sends 3 words 0x11, 0x22, 0x33 (last on 0x33) with out_ack held high -> grant=2; out_data sequence 0x11, 0x22, 0x33 on consecutive cycles; out_last only on 0x33; IDLE after the third word.
REQ-032 Round-robin fairness: all four ports continuously send 1-word packets -> grant order is 0, 1, 2, 3, 0, ..., and no port is granted twice before the others are each granted once.
REQ-033 Backpressure: hold out_ack low for 5 cycles mid-packet -> out_data stays stable, the granted ack stays low, and no words are lost or duplicated after out_ack returns high.
REQ-034 Timeout with timeout=4: in1 sends one word without last, then drops stb -> timeout_err pulses exactly 4 cycles after that transfer, and a pending in2 request is granted next.
REQ-035 Non-interleaving: in0 sends a 4-word packet while in3 requests continuously -> all 4 in0 words appear contiguously on the output before any in3 word.
REQ-036 Reset mid-packet: assert rst while LOCKED with out_stb high -> out_stb=0, locked=0, grant=0 after the edge, and the next arbitration favours port 0.

Source files
------------

// File: rtl/fifo_arbiter.sv
// Four-port packet arbiter feeding a downstream fifo write port.
// Round-robin grant per packet, registered output stage, idle timeout on a stalled grant.
//
// state  | meaning
// IDLE   | no grant held; arbitrate among requesting ports
// LOCKED | grant held until a last word is transferred or the idle timeout expires
module fifo_arbiter #(
  parameter int width   = 8,
  parameter int timeout = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in0_data,
  input  logic [width-1:0] in1_data,
  input  logic [width-1:0] in2_data,
  input  logic [width-1:0] in3_data,
  input  logic             in0_last,
  input  logic             in1_last,
  input  logic             in2_last,
  input  logic             in3_last,
  input  logic             in0_stb,
  input  logic             in1_stb,
  input  logic             in2_stb,
  input  logic             in3_stb,
  output logic             in0_ack,
  output logic             in1_ack,
  output logic             in2_ack,
  output logic             in3_ack,
  output logic [width-1:0] out_data,
  output logic             out_last,
  output logic             out_stb,
  input  logic             out_ack,
  output logic [1:0]       grant,
  output logic             locked,
  output logic             timeout_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [15:0] timeout_last = 16'(timeout - 1);

  state_t                  state;
  state_t                  state_next;
  logic [3:0][width-1:0]   port_data;
  logic [3:0]              port_stb;
  logic [3:0]              port_last;
  logic [3:0]              port_ack;
  logic [1:0]              last_grant;
  logic [1:0]              pick;
  logic                    pick_valid;
  logic [15:0]             idle_cnt;
  logic [width-1:0]        sel_data;
  logic                    sel_stb;
  logic                    sel_last;
  logic                    ack_en;
  logic                    xfer;
  logic                    hit_timeout;
  logic                    release_grant;

  assign port_data = {in3_data, in2_data, in1_data, in0_data};
  assign port_stb  = {in3_stb, in2_stb, in1_stb, in0_stb};
  assign port_last = {in3_last, in2_last, in1_last, in0_last};

  assign sel_data = port_data[grant];
  assign sel_stb  = port_stb[grant];
  assign sel_last = port_last[grant];

  // The output register can take a word when it is empty or being drained this cycle.
  assign ack_en = (state == LOCKED) && (!out_stb || out_ack);
  assign xfer   = ack_en && sel_stb;

  // A transfer in the same cycle always beats the timeout.
  assign hit_timeout   = (state == LOCKED) && !xfer && (idle_cnt == timeout_last);
  assign release_grant = (xfer && sel_last) || hit_timeout;

  assign port_ack = ack_en ? (4'b0001 << grant) : 4'b0000;
  assign in0_ack  = port_ack[0];
  assign in1_ack  = port_ack[1];
  assign in2_ack  = port_ack[2];
  assign in3_ack  = port_ack[3];

  assign locked = (state == LOCKED);

  // Search starts one past the last grant; the port just served is considered last.
  always_comb begin
    pick       = last_grant;
    pick_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!pick_valid && port_stb[last_grant + 2'(i)]) begin
        pick       = last_grant + 2'(i);
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (release_grant) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= 2'd0;
      last_grant  <= 2'd3;
      idle_cnt    <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= hit_timeout;
      if (state == IDLE) begin
        if (pick_valid) begin
          grant    <= pick;
          idle_cnt <= 16'd0;
        end
      end else if (xfer || hit_timeout) begin
        idle_cnt <= 16'd0;
      end else begin
        idle_cnt <= idle_cnt + 16'd1;
      end
      if (release_grant) begin
        last_grant <= grant;
      end
    end
  end

  // A consume and a new transfer on the same edge replace the word and keep out_stb high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_stb  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else if (xfer) begin
      out_stb  <= 1'b1;
      out_last <= sel_last;
      out_data <= sel_data;
    end else if (out_stb && out_ack) begin
      out_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: directed scenarios plus randomized packet traffic
// checked against a packet-level round-robin model.
module tb_fifo_arbiter;
  localparam int W        = 8;
  localparam int TO_LONG  = 16;
  localparam int TO_SHORT = 4;

  logic         clk = 1'b0;
  logic         rst;

  logic [W-1:0] in_data [4];
  logic [3:0]   in_last;
  logic [3:0]   in_stb;
  logic [3:0]   ack;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_stb;
  logic         out_ack;
  logic [1:0]   grant;
  logic         locked;
  logic         timeout_err;

  logic [W-1:0] t_in_data [4];
  logic [3:0]   t_in_last;
  logic [3:0]   t_in_stb;
  logic [3:0]   t_ack;
  logic [W-1:0] t_out_data;
  logic         t_out_last;
  logic         t_out_stb;
  logic         t_out_ack;
  logic [1:0]   t_grant;
  logic         t_locked;
  logic         t_timeout_err;

  int checks   = 0;
  int failures = 0;

  // per-port pending words, bit 8 = last
  logic [8:0] pq [4][$];
  logic [8:0] exp_q [$];
  logic [8:0] got_q [$];
  int         xfer_order [$];

  always #5 clk = ~clk;

  fifo_arbiter #(.width(W), .timeout(TO_LONG)) dut (
    .clk(clk), .rst(rst),
    .in0_data(in_data[0]), .in1_data(in_data[1]), .in2_data(in_data[2]), .in3_data(in_data[3]),
    .in0_last(in_last[0]), .in1_last(in_last[1]), .in2_last(in_last[2]), .in3_last(in_last[3]),
    .in0_stb(in_stb[0]), .in1_stb(in_stb[1]), .in2_stb(in_stb[2]), .in3_stb(in_stb[3]),
    .in0_ack(ack[0]), .in1_ack(ack[1]), .in2_ack(ack[2]), .in3_ack(ack[3]),
    .out_data(out_data), .out_last(out_last), .out_stb(out_stb), .out_ack(out_ack),
    .grant(grant), .locked(locked), .timeout_err(timeout_err)
  );

  fifo_arbiter #(.width(W), .timeout(TO_SHORT)) dut_to (
    .clk(clk), .rst(rst),
    .in0_data(t_in_data[0]), .in1_data(t_in_data[1]), .in2_data(t_in_data[2]), .in3_data(t_in_data[3]),
    .in0_last(t_in_last[0]), .in1_last(t_in_last[1]), .in2_last(t_in_last[2]), .in3_last(t_in_last[3]),
    .in0_stb(t_in_stb[0]), .in1_stb(t_in_stb[1]), .in2_stb(t_in_stb[2]), .in3_stb(t_in_stb[3]),
    .in0_ack(t_ack[0]), .in1_ack(t_ack[1]), .in2_ack(t_ack[2]), .in3_ack(t_ack[3]),
    .out_data(t_out_data), .out_last(t_out_last), .out_stb(t_out_stb), .out_ack(t_out_ack),
    .grant(t_grant), .locked(t_locked), .timeout_err(t_timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 4; p++) begin
      in_data[p]   = '0;
      t_in_data[p] = '0;
      pq[p].delete();
    end
    in_last   = '0;
    in_stb    = '0;
    out_ack   = 1'b1;
    t_in_last = '0;
    t_in_stb  = '0;
    t_out_ack = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Packet-level model: whole packets, round-robin over non-empty ports from last grant + 1.
  task automatic build_expected();
    logic [8:0] tmp [4][$];
    logic [8:0] w;
    int  lg;
    int  p;
    bit  found;
    bit  more;
    for (int q = 0; q < 4; q++) tmp[q] = pq[q];
    exp_q.delete();
    lg   = 3;
    more = 1'b1;
    while (more) begin
      found = 1'b0;
      p     = 0;
      for (int i = 1; i <= 4; i++) begin
        if (!found && tmp[(lg + i) % 4].size() > 0) begin
          found = 1'b1;
          p     = (lg + i) % 4;
        end
      end
      if (!found) begin
        more = 1'b0;
      end else begin
        do begin
          w = tmp[p].pop_front();
          exp_q.push_back(w);
        end while (!w[8] && tmp[p].size() > 0);
        lg = p;
      end
    end
  endtask

  // mode 0: out_ack always high; 1: random (mostly high); 2: low during cycles 4..8
  task automatic run_engine(input int mode, input int budget);
    int         cyc;
    bit         done;
    bit         prev_hold;
    logic [8:0] prev_out;
    got_q.delete();
    xfer_order.delete();
    cyc       = 0;
    done      = 1'b0;
    prev_hold = 1'b0;
    prev_out  = '0;
    while (!done) begin
      for (int p = 0; p < 4; p++) begin
        in_stb[p] = (pq[p].size() > 0);
        if (in_stb[p]) begin
          in_data[p] = pq[p][0][7:0];
          in_last[p] = pq[p][0][8];
        end else begin
          in_data[p] = '0;
          in_last[p] = 1'b0;
        end
      end
      case (mode)
        0:       out_ack = 1'b1;
        1:       out_ack = ($urandom_range(0, 3) != 0);
        default: out_ack = !(cyc >= 4 && cyc < 9);
      endcase
      #1;
      if (prev_hold) begin
        checks++;
        if ({out_stb, out_last, out_data} !== {1'b1, prev_out})
          $display("FAIL hold_stable: got stb=%0b word=%h expected stb=1 word=%h", out_stb, {out_last, out_data}, prev_out);
      end
      if (out_stb && !out_ack) begin
        checks++;
        if (ack !== 4'b0000) begin
          failures++;
          $display("FAIL stall_ack: got %b expected 0000", ack);
        end
      end
      for (int p = 0; p < 4; p++) begin
        if (ack[p] && in_stb[p]) begin
          void'(pq[p].pop_front());
          xfer_order.push_back(p);
        end
      end
      if (out_stb && out_ack) got_q.push_back({out_last, out_data});
      prev_hold = out_stb && !out_ack;
      prev_out  = {out_last, out_data};
      step();
      cyc++;
      if (pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() == 0 && !out_stb) done = 1'b1;
      if (!done && cyc >= budget) begin
        checks++;
        failures++;
        $display("FAIL engine_budget: got %0d cycles without draining, expected under %0d", cyc, budget);
        done = 1'b1;
      end
    end
    in_stb = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst    = 1'b1;
    in_stb = 4'hF;
    step();
    step();
    checks++;
    if ({out_stb, out_last, out_data} !== '0) begin
      failures++;
      $display("FAIL reset_out: got stb=%0b last=%0b data=%h expected 0 0 00", out_stb, out_last, out_data);
    end
    checks++;
    if ({grant, locked, timeout_err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_state: got grant=%0d locked=%0b terr=%0b expected 0 0 0", grant, locked, timeout_err);
    end
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ack: got %b expected 0000", ack);
    end
    checks++;
    if ({t_grant, t_locked, t_out_stb, t_timeout_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state_to: got grant=%0d locked=%0b stb=%0b expected 0 0 0", t_grant, t_locked, t_out_stb);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL arb_cycle_ack: got %b expected 0000", ack);
    end
    step();
    checks++;
    if (grant !== 2'd0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL first_grant: got grant=%0d locked=%0b expected 0 1", grant, locked);
    end
    in_stb = '0;
    do_reset();
  endtask

  task automatic test_single_packet();
    logic [7:0] words [3];
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    do_reset();
    in_stb[2]  = 1'b1;
    in_data[2] = words[0];
    #1;
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL single_arb_ack: got %b expected 0000", ack);
    end
    step();
    checks++;
    if (grant !== 2'd2 || locked !== 1'b1 || out_stb !== 1'b0) begin
      failures++;
      $display("FAIL single_grant: got grant=%0d locked=%0b stb=%0b expected 2 1 0", grant, locked, out_stb);
    end
    for (int i = 0; i < 3; i++) begin
      in_data[2] = words[i];
      in_last[2] = (i == 2);
      #1;
      checks++;
      if (ack !== 4'b0100) begin
        failures++;
        $display("FAIL single_ack[%0d]: got %b expected 0100", i, ack);
      end
      step();
      checks++;
      if ({out_stb, out_last, out_data} !== {1'b1, 1'(i == 2), words[i]}) begin
        failures++;
        $display("FAIL single_word[%0d]: got stb=%0b last=%0b data=%h expected 1 %0b %h",
                 i, out_stb, out_last, out_data, (i == 2), words[i]);
      end
    end
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: got locked=%0b expected 0", locked);
    end
    in_stb  = '0;
    in_last = '0;
    step();
    checks++;
    if (out_stb !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: got out_stb=%0b expected 0", out_stb);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 3; k++) pq[p].push_back({1'b1, 8'($urandom)});
    build_expected();
    run_engine(0, 200);
    checks++;
    if (xfer_order.size() != 12) begin
      failures++;
      $display("FAIL rr_count: got %0d expected 12", xfer_order.size());
    end
    for (int i = 0; i < xfer_order.size() && i < 12; i++) begin
      checks++;
      if (xfer_order[i] != i % 4) begin
        failures++;
        $display("FAIL rr_order[%0d]: got port %0d expected %0d", i, xfer_order[i], i % 4);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rr_stream_len: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rr_stream[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int j = 0; j < 6; j++) pq[0].push_back({1'(j == 5), 8'($urandom)});
    build_expected();
    run_engine(2, 200);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_stream_len: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_stream[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    do_reset();
    t_in_stb      = 4'b0110;
    t_in_data[1]  = 8'hA5;
    t_in_data[2]  = 8'h5A;
    step();
    checks++;
    if (t_grant !== 2'd1 || t_locked !== 1'b1) begin
      failures++;
      $display("FAIL to_grant: got grant=%0d locked=%0b expected 1 1", t_grant, t_locked);
    end
    checks++;
    if (t_ack !== 4'b0010) begin
      failures++;
      $display("FAIL to_ack: got %b expected 0010", t_ack);
    end
    step();
    checks++;
    if (t_out_stb !== 1'b1 || t_out_data !== 8'hA5) begin
      failures++;
      $display("FAIL to_word: got stb=%0b data=%h expected 1 a5", t_out_stb, t_out_data);
    end
    t_in_stb[1] = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      if (t_timeout_err) seen = 1'b1;
    end
    checks++;
    if (!seen || n != TO_SHORT) begin
      failures++;
      $display("FAIL to_pulse_time: got seen=%0b after %0d cycles expected after %0d", seen, n, TO_SHORT);
    end
    checks++;
    if (t_locked !== 1'b0 || t_grant !== 2'd1) begin
      failures++;
      $display("FAIL to_release: got locked=%0b grant=%0d expected 0 1", t_locked, t_grant);
    end
    step();
    checks++;
    if (t_timeout_err !== 1'b0 || t_grant !== 2'd2 || t_locked !== 1'b1) begin
      failures++;
      $display("FAIL to_next: got terr=%0b grant=%0d locked=%0b expected 0 2 1", t_timeout_err, t_grant, t_locked);
    end
    t_in_stb = '0;
  endtask

  task automatic test_non_interleave();
    do_reset();
    for (int j = 0; j < 4; j++) pq[0].push_back({1'(j == 3), 8'($urandom)});
    for (int k = 0; k < 3; k++) pq[3].push_back({1'b1, 8'($urandom)});
    build_expected();
    run_engine(0, 200);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= xfer_order.size() || xfer_order[i] != 0) begin
        failures++;
        $display("FAIL ni_order[%0d]: got port %0d expected 0", i, (i < xfer_order.size()) ? xfer_order[i] : -1);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ni_stream_len: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ni_stream[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    out_ack    = 1'b0;
    in_stb[1]  = 1'b1;
    in_data[1] = 8'h77;
    step();
    step();
    checks++;
    if (locked !== 1'b1 || out_stb !== 1'b1 || grant !== 2'd1) begin
      failures++;
      $display("FAIL mid_setup: got locked=%0b stb=%0b grant=%0d expected 1 1 1", locked, out_stb, grant);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_stb !== 1'b0 || locked !== 1'b0 || grant !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset: got stb=%0b locked=%0b grant=%0d expected 0 0 0", out_stb, locked, grant);
    end
    in_stb = 4'b0011;
    #1;
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL mid_ack: got %b expected 0000", ack);
    end
    step();
    checks++;
    if (grant !== 2'd0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL mid_regrant: got grant=%0d locked=%0b expected 0 1", grant, locked);
    end
    in_stb  = '0;
    out_ack = 1'b1;
  endtask

  task automatic test_random();
    int npk;
    int len;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int p = 0; p < 4; p++) begin
        npk = $urandom_range(0, 3);
        for (int k = 0; k < npk; k++) begin
          len = $urandom_range(1, 4);
          for (int j = 0; j < len; j++) pq[p].push_back({1'(j == len - 1), 8'($urandom)});
        end
      end
      build_expected();
      run_engine(1, 2000);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL rand_stream_len[%0d]: got %0d expected %0d", it, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand_stream[%0d][%0d]: got %h expected %h", it, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_non_interleave();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
